// File: rtl/ps2_line_assembler_pkg.sv
// Shared definitions for the PS/2 line assembler: ASCII control codes,
// printable range, counter constants and the FSM state encoding.
package ps2_line_assembler_pkg;

    localparam logic [7:0] ASCII_BS         = 8'h08;
    localparam logic [7:0] ASCII_CR         = 8'h0D;
    localparam logic [7:0] ASCII_ESC        = 8'h1B;
    localparam logic [7:0] ASCII_SPACE      = 8'h20;
    localparam logic [7:0] ASCII_TILDE      = 8'h7E;
    localparam logic [7:0] ASCII_LC_A       = 8'h61;
    localparam logic [7:0] ASCII_LC_Z       = 8'h7A;
    localparam logic [7:0] ASCII_CASE_DELTA = 8'h20;

    localparam int              COUNT_W    = 6;
    localparam logic [5:0]      COUNT_ZERO = 6'd0;
    localparam logic [5:0]      COUNT_ONE  = 6'd1;

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_EMIT    = 1'b1
    } state_e;

    // Lower-case letters fold to upper case so commands compare uniformly.
    function automatic logic [7:0] to_upper(input logic [7:0] c);
        logic [7:0] r;
        if ((c >= ASCII_LC_A) && (c <= ASCII_LC_Z)) begin
            r = c - ASCII_CASE_DELTA;
        end else begin
            r = c;
        end
        return r;
    endfunction

    function automatic logic is_printable_char(input logic [7:0] c);
        return (c >= ASCII_SPACE) && (c <= ASCII_TILDE);
    endfunction

endpackage

// File: rtl/ps2_line_assembler_classify.sv
// Combinational decode of one keyboard byte into the classes the line
// assembler acts on, plus its upper-cased form.
module ascii_classify
    import ps2_line_assembler_pkg::*;
(
    input  logic [7:0] byte_i,
    output logic       is_printable_o,
    output logic       is_bs_o,
    output logic       is_cr_o,
    output logic       is_esc_o,
    output logic [7:0] upper_o
);

    // Pure decode; no state.
    always_comb begin
        is_printable_o = is_printable_char(byte_i);
        is_bs_o        = (byte_i == ASCII_BS);
        is_cr_o        = (byte_i == ASCII_CR);
        is_esc_o       = (byte_i == ASCII_ESC);
        upper_o        = to_upper(byte_i);
    end

endmodule

// File: rtl/ps2_line_assembler.sv
// Collects decoded PS/2 key bytes into an editable line buffer and commits
// the line to input_line on Enter, with a one-cycle handshake gap (EMIT).
module ps2_line_assembler
    import ps2_line_assembler_pkg::*;
#(
    parameter int         MAX_CHARS = 32,
    parameter logic [7:0] PAD_CHAR  = 8'h20
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic [7:0]               ascii,
    input  logic                     ascii_valid,
    output logic                     ascii_ready,
    output logic [8*MAX_CHARS-1:0]   input_line,
    output logic                     line_ready,
    output logic [5:0]               char_count,
    output logic                     overflow
);

    localparam logic [COUNT_W-1:0] MAX_COUNT = COUNT_W'(MAX_CHARS);

    state_e                  state_q;
    logic                    ready_q;
    logic                    line_ready_q;
    logic                    overflow_q;
    logic [COUNT_W-1:0]      count_q;
    logic [8*MAX_CHARS-1:0]  line_q;
    logic [7:0]              slot_q [MAX_CHARS];

    logic                    is_printable_s;
    logic                    is_bs_s;
    logic                    is_cr_s;
    logic                    is_esc_s;
    logic [7:0]              upper_s;

    logic                    accept_s;
    logic                    store_s;
    logic                    drop_s;
    logic                    bs_s;
    logic                    esc_s;
    logic                    commit_s;
    logic [8*MAX_CHARS-1:0]  slots_flat_s;

    ascii_classify u_classify (
        .byte_i         (ascii),
        .is_printable_o (is_printable_s),
        .is_bs_o        (is_bs_s),
        .is_cr_o        (is_cr_s),
        .is_esc_o       (is_esc_s),
        .upper_o        (upper_s)
    );

    // Decode the accepted byte into one buffer action.
    always_comb begin
        accept_s = ascii_valid && ready_q && (state_q == ST_COLLECT);
        store_s  = accept_s && is_printable_s && (count_q <  MAX_COUNT);
        drop_s   = accept_s && is_printable_s && (count_q >= MAX_COUNT);
        bs_s     = accept_s && is_bs_s  && (count_q != COUNT_ZERO);
        esc_s    = accept_s && is_esc_s;
        commit_s = accept_s && is_cr_s  && (count_q != COUNT_ZERO);
    end

    // Slot 0 lands in the top byte of the committed line.
    always_comb begin
        slots_flat_s = {MAX_CHARS{PAD_CHAR}};
        for (int i = 0; i < MAX_CHARS; i++) begin
            slots_flat_s[8*(MAX_CHARS-1-i) +: 8] = slot_q[i];
        end
    end

    // Working buffer: append, backspace and clear.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < MAX_CHARS; i++) begin
                slot_q[i] <= PAD_CHAR;
            end
        end else begin
            for (int i = 0; i < MAX_CHARS; i++) begin
                if (esc_s || commit_s) begin
                    slot_q[i] <= PAD_CHAR;
                end else if (store_s && (count_q == COUNT_W'(i))) begin
                    slot_q[i] <= upper_s;
                end else if (bs_s && (count_q == COUNT_W'(i + 1))) begin
                    slot_q[i] <= PAD_CHAR;
                end else begin
                    slot_q[i] <= slot_q[i];
                end
            end
        end
    end

    // Character count and sticky overflow flag.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count_q    <= COUNT_ZERO;
            overflow_q <= 1'b0;
        end else begin
            if (store_s) begin
                count_q <= count_q + COUNT_ONE;
            end else if (bs_s) begin
                count_q <= count_q - COUNT_ONE;
            end else if (esc_s || commit_s) begin
                count_q <= COUNT_ZERO;
            end else begin
                count_q <= count_q;
            end

            if (drop_s) begin
                overflow_q <= 1'b1;
            end else if (esc_s || commit_s) begin
                overflow_q <= 1'b0;
            end else begin
                overflow_q <= overflow_q;
            end
        end
    end

    // COLLECT/EMIT sequencing with registered ready, pulse and committed line.
    // ready_q stays low through reset and rises on the first edge after it.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_COLLECT;
            ready_q      <= 1'b0;
            line_ready_q <= 1'b0;
            line_q       <= {MAX_CHARS{PAD_CHAR}};
        end else begin
            case (state_q)
                ST_COLLECT: begin
                    if (commit_s) begin
                        state_q      <= ST_EMIT;
                        ready_q      <= 1'b0;
                        line_ready_q <= 1'b1;
                        line_q       <= slots_flat_s;
                    end else begin
                        state_q      <= ST_COLLECT;
                        ready_q      <= 1'b1;
                        line_ready_q <= 1'b0;
                        line_q       <= line_q;
                    end
                end
                ST_EMIT: begin
                    state_q      <= ST_COLLECT;
                    ready_q      <= 1'b1;
                    line_ready_q <= 1'b0;
                    line_q       <= line_q;
                end
                default: begin
                    state_q      <= ST_COLLECT;
                    ready_q      <= 1'b0;
                    line_ready_q <= 1'b0;
                    line_q       <= line_q;
                end
            endcase
        end
    end

    assign ascii_ready = ready_q;
    assign line_ready  = line_ready_q;
    assign input_line  = line_q;
    assign char_count  = count_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_ps2_line_assembler.sv
// Self-checking bench for ps2_line_assembler: expected committed lines are
// queued as keystrokes are sent and compared when line_ready pulses.
module tb_ps2_line_assembler;

    localparam int MAX_CHARS = 32;
    localparam int LW        = 8 * MAX_CHARS;
    localparam int WAIT_MAX  = 20;

    logic           clock;
    logic           resetn;
    logic [7:0]     ascii;
    logic           ascii_valid;
    logic           ascii_ready;
    logic [LW-1:0]  input_line;
    logic           line_ready;
    logic [5:0]     char_count;
    logic           overflow;

    int             n_checks;
    int             n_errors;
    logic [LW-1:0]  exp_q[$];
    logic [LW-1:0]  saved_line;

    ps2_line_assembler #(.MAX_CHARS(MAX_CHARS), .PAD_CHAR(8'h20)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .ascii       (ascii),
        .ascii_valid (ascii_valid),
        .ascii_ready (ascii_ready),
        .input_line  (input_line),
        .line_ready  (line_ready),
        .char_count  (char_count),
        .overflow    (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] line_of(input string s);
        logic [LW-1:0] v;
        for (int i = 0; i < MAX_CHARS; i++) begin
            v[LW-1-8*i -: 8] = (i < s.len()) ? s[i] : 8'h20;
        end
        return v;
    endfunction

    // Drive one byte and hold it until the DUT accepts it on a rising edge.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clock);
        ascii       = b;
        ascii_valid = 1'b1;
        while (!ascii_ready && n < WAIT_MAX) begin
            @(negedge clock);
            n++;
        end
        if (n >= WAIT_MAX) check_eq("accept_timeout", n, 0);
        @(posedge clock);
        #1;
        ascii_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic reset_checks(input string tag);
        check_eq({tag, "_ready"},  ascii_ready, 1'b0);
        check_eq({tag, "_pulse"},  line_ready,  1'b0);
        check_eq({tag, "_count"},  char_count,  6'd0);
        check_eq({tag, "_ovf"},    overflow,    1'b0);
        check_eq({tag, "_line"},   input_line,  line_of(""));
    endtask

    // After an accepted CR: EMIT cycle, then back to COLLECT.
    task automatic commit_checks(input string tag);
        check_eq({tag, "_emit_ready"}, ascii_ready, 1'b0);
        check_eq({tag, "_emit_pulse"}, line_ready,  1'b1);
        check_eq({tag, "_emit_count"}, char_count,  6'd0);
        check_eq({tag, "_emit_ovf"},   overflow,    1'b0);
        @(posedge clock);
        #1;
        check_eq({tag, "_post_ready"}, ascii_ready, 1'b1);
        check_eq({tag, "_post_pulse"}, line_ready,  1'b0);
    endtask

    // Scoreboard: every pulse must match the oldest queued line.
    always @(negedge clock) begin
        if (resetn && line_ready) begin
            if (exp_q.size() == 0) check_eq("spurious_pulse", line_ready, 1'b0);
            else                   check_eq("line", input_line, exp_q.pop_front());
        end
    end

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        resetn      = 1'b0;
        ascii       = 8'h00;
        ascii_valid = 1'b0;

        repeat (2) @(posedge clock);
        #1;
        reset_checks("por");
        @(negedge clock);
        resetn = 1'b1;
        #1;
        check_eq("rel_ready_before_edge", ascii_ready, 1'b0);
        @(posedge clock);
        #1;
        check_eq("rel_ready_after_edge", ascii_ready, 1'b1);

        // Lower case folded, digits and spaces kept.
        send_str("set a 045");
        check_eq("set_count", char_count, 6'd9);
        exp_q.push_back(line_of("SET A 045"));
        send_byte(8'h0D);
        check_eq("set_top9", input_line[LW-1 -: 72], 72'h534554204120303435);
        check_eq("set_rest", input_line[LW-73:0], {23{8'h20}});
        commit_checks("set");

        // Backspace edits, non-printables ignored.
        send_str("FIRX");
        send_byte(8'h08);
        send_byte(8'h01);
        send_byte(8'h80);
        send_str("E");
        check_eq("fire_count", char_count, 6'd4);
        exp_q.push_back(line_of("FIRE"));
        send_byte(8'h0D);
        commit_checks("fire");

        // Overflow at capacity; commit clears it.
        for (int i = 0; i < MAX_CHARS + 1; i++) send_byte(8'h41);
        check_eq("full_count", char_count, 6'd32);
        check_eq("full_ovf",   overflow,   1'b1);
        exp_q.push_back({MAX_CHARS{8'h41}});
        send_byte(8'h0D);
        check_eq("full_line_now", input_line, {MAX_CHARS{8'h41}});
        commit_checks("full");

        // Empty CR, BS at zero, ESC discards and clears overflow.
        saved_line = input_line;
        send_byte(8'h0D);
        send_byte(8'h08);
        check_eq("empty_count", char_count, 6'd0);
        send_str("SET");
        check_eq("esc_pre_count", char_count, 6'd3);
        send_byte(8'h1B);
        check_eq("esc_count", char_count, 6'd0);
        for (int i = 0; i < MAX_CHARS + 1; i++) send_byte(8'h5A);
        send_byte(8'h1B);
        check_eq("esc_ovf", overflow, 1'b0);
        send_byte(8'h0D);
        repeat (2) @(posedge clock);
        #1;
        check_eq("idle_line_held", input_line, saved_line);
        check_eq("idle_count", char_count, 6'd0);

        // Byte presented during EMIT waits and starts the next line.
        send_str("X");
        exp_q.push_back(line_of("X"));
        send_byte(8'h0D);
        send_byte(8'h56);
        check_eq("v_count", char_count, 6'd1);
        exp_q.push_back(line_of("V"));
        send_byte(8'h0D);
        commit_checks("v");

        // Reset mid-line.
        send_str("AB");
        @(negedge clock);
        resetn = 1'b0;
        #1;
        reset_checks("mid");
        @(negedge clock);
        resetn = 1'b1;

        // Reset during EMIT: the pulse is cut short and the line discarded.
        send_str("Q");
        send_byte(8'h0D);
        resetn = 1'b0;
        #1;
        reset_checks("emit");
        @(negedge clock);
        resetn = 1'b1;

        send_str("ok");
        exp_q.push_back(line_of("OK"));
        send_byte(8'h0D);
        commit_checks("ok");

        repeat (2) @(posedge clock);
        check_eq("sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ps2_line_assembler.md
PS2_LINE_ASSEMBLER -- requirements
Module: ps2_line_assembler

Interface
REQ-001 Parameter MAX_CHARS, default 32: line capacity in characters; line width is 8*MAX_CHARS bits.
REQ-002 Parameter PAD_CHAR, default 8'h20: fill byte for unused character slots.
REQ-003 clock  in  1  single clock; all state changes on its rising edge.
REQ-004 resetn  in  1  reset, asynchronous assert, active-low.
REQ-005 ascii  in  8  decoded key byte from the PS/2 keyboard decoder.
REQ-006 ascii_valid  in  1  ascii holds a new byte this cycle.
REQ-007 ascii_ready  out  1  byte accepted on the edge where ascii_valid & ascii_ready.
REQ-008 input_line  out  8*MAX_CHARS  last committed line; char 0 in bits [top:top-7], left-aligned, PAD_CHAR padded.
REQ-009 line_ready  out  1  one-cycle pulse marking a new input_line.
REQ-010 char_count  out  6  characters currently in the working buffer, 0..MAX_CHARS.
REQ-011 overflow  out  1  sticky; a printable byte was dropped because the buffer was full.

Function
REQ-012 FSM states: COLLECT and EMIT; reset state COLLECT.
REQ-013 ascii_ready = 1 in COLLECT and 0 in EMIT; bytes are not accepted in EMIT.
REQ-014 Printable byte 8'h20..8'h7E, count < MAX_CHARS: stored at slot char_count, char_count +1.
REQ-015 Bytes 8'h61..8'h7A are stored minus 8'h20, so commands are upper case.
REQ-016 Printable byte, count = MAX_CHARS: dropped, count unchanged, overflow set.
REQ-017 Backspace 8'h08, count > 0: slot count-1 := PAD_CHAR, count -1; at count 0, no effect.
REQ-018 Escape 8'h1B: all slots := PAD_CHAR, count := 0, overflow cleared; input_line unchanged.
REQ-019 Enter 8'h0D, count > 0: next edge loads input_line from the working buffer (unused slots PAD_CHAR), pulses line_ready, clears the buffer, count := 0, overflow := 0, FSM to EMIT.
REQ-020 Enter with count = 0: ignored; no pulse, input_line unchanged.
REQ-021 Enter accepted on edge N: input_line and line_ready change on edge N; line_ready high for exactly cycle N..N+1; EMIT lasts one cycle; ascii_ready returns high after edge N+1.
REQ-022 input_line holds between commits, so the downstream interpreter can sample it multiple cycles after line_ready.
REQ-023 Other bytes 8'h00..8'h1F, 8'h7F..8'hFF: consumed, no state change.
REQ-024 ascii_valid with ascii_ready low: byte is not consumed; the source holds it until accepted.

Reset
REQ-025 resetn low asynchronously forces: FSM COLLECT, buffer all PAD_CHAR, input_line all PAD_CHAR, line_ready 0, char_count 0, overflow 0.
REQ-026 Reset asserted during EMIT or mid-line discards the partial line; no line_ready pulse follows reset.
REQ-027 ascii_ready is 0 while resetn is low and 1 from the first edge after release.

Structure
REQ-028 Shared package holds ASCII constants (BS 8'h08, CR 8'h0D, ESC 8'h1B, SPACE 8'h20, TILDE 8'h7E) and the FSM state encoding.
REQ-029 One sub-module, ascii_classify, is combinational: outputs is_printable, is_bs, is_cr, is_esc and the upper-cased byte.
REQ-030 Working buffer is a MAX_CHARS x 8 register array; no RAM inference required.

Verification
REQ-031 Reset, then send "set a 045" + CR -> one line_ready pulse; input_line top 9 bytes = 53 45 54 20 41 20 30 34 35; remaining 23 bytes 8'h20; ascii_ready low one cycle.
REQ-032 Send "FIRX", BS, "E", CR -> input_line starts 46 49 52 45; char_count 4 before CR, 0 after.
REQ-033 Send 33 'A' bytes -> char_count 32, overflow 1; CR -> 32 bytes 8'h41, overflow 0.
REQ-034 CR on empty buffer; BS at count 0; ESC after "SET" -> no line_ready, count 0, input_line unchanged.
REQ-035 ascii_valid held high through EMIT with 'V' -> 'V' accepted only after EMIT, lands in slot 0 of the next line.
REQ-036 resetn low mid-line and during EMIT -> all outputs at reset values immediately; next CR-terminated line commits normally.
